dec2bin_encoder: RTL and testbench
==================================

# dec2bin_encoder

Sequential decimal-to-binary encoder for the ALU display path. It accepts a sign code plus three BCD digits through a valid/ready handshake. It produces the equivalent 16-bit two's-complement value in the range -999..999 using one multiply-by-10-and-add step per clock. It is the inverse of the ALU's binary-to-7-segment digit splitter: it uses the same digit encoding, with sign code 10 meaning minus.

## Interface

Parameters: none (width fixed at 16-bit output, 3 decimal digits).

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  digit set present on digit3..digit0
- in_ready  output  1  block can accept a digit set; high only in IDLE
- digit3  input  4  sign code: 0 = plus, 10 = minus, any other value = error
- digit2  input  4  hundreds BCD digit
- digit1  input  4  tens BCD digit
- digit0  input  4  units BCD digit
- out  output  16  two's-complement result; registered
- out_valid  output  1  out and err are valid; registered
- out_ready  input  1  consumer takes the result
- err  output  1  illegal digit in the accepted set; registered

## Operation

- Acceptance occurs on a rising edge where in_valid and in_ready are both high.
- At acceptance, digit3..digit0 are captured into internal registers. Later input changes are ignored until the next acceptance.
- State machine states are IDLE, CONV, SIGN, DONE.
  - IDLE -> CONV on acceptance; acc cleared to 0, step counter cleared to 0.
  - CONV holds for exactly 3 cycles, processing the hundreds, tens, then units digit. Each cycle computes acc <= acc*10 + digit, with acc*10 formed as (acc<<3)+(acc<<1). acc is 10 bits wide; 999 maximum, so no overflow. After the third step, go to SIGN.
  - SIGN performs out <= minus ? (0 - zero-extended acc) : zero-extended acc, as a 16-bit result, then goes to DONE.
  - DONE holds while out_ready is low. When out_ready is high it goes to IDLE and out_valid clears on that edge.
- in_ready is decoded from state == IDLE only, with no combinational path from out_ready.
- Error checking is done at capture: err_flag = (digit3 not 0 and not 10) or any of digit2..digit0 > 9.
  - On error the conversion still runs the full sequence, so latency is identical.
  - In SIGN, out is forced to 0x0000 and err is set.
- Minus zero (10,0,0,0) yields out = 0x0000 with err = 0.
- out and err keep their values after the DONE->IDLE handoff until the next SIGN overwrites them; only out_valid clears.

## Timing

- Reset values: out = 0x0000, out_valid = 0, err = 0, state = IDLE, acc = 0. Consequently in_ready = 1 in the first cycle after the reset edge.
- in_valid is ignored during any cycle where rst is high.
- Reset in any state, including mid-CONV or DONE with out_valid high, aborts the operation. The captured digits are discarded, with no partial result and no out_valid pulse.
- Latency, with acceptance edge at cycle T:
  - CONV in cycles T+1..T+3
  - SIGN in cycle T+4
  - out_valid = 1 from cycle T+5
- Throughput: the minimum accept-to-accept interval is 6 cycles when out_ready is held high. in_ready rises in the cycle after the out_valid/out_ready handoff edge.
- Backpressure: out, err and out_valid stay stable while out_valid = 1 and out_ready = 0, for any duration.
- Simultaneous in_valid with DONE: there is no acceptance, because in_ready = 0. The input must be held by the producer.

## Test plan

- Input (0,9,9,9), out_ready = 1 -> out = 0x03E7, err = 0; out_valid rises exactly 5 cycles after the acceptance edge and lasts 1 cycle.
- Input (10,9,9,9) -> out = 0xFC19 (-999). Input (10,1,2,3) -> out = 0xFF85 (-123). Input (10,0,0,0) -> out = 0x0000, err = 0.
- Error cases:
  - Input (0,1,12,3) -> out = 0x0000, err = 1, same 5-cycle latency.
  - Input (7,0,0,1) -> err = 1.
  - A following legal input (0,0,0,5) -> out = 0x0005 with err = 0.
- Backpressure: input (0,4,5,6) with out_ready low for 10 cycles after out_valid -> out = 0x01C8 held stable; in_ready stays 0. A new in_valid offered during the stall is not accepted. Raising out_ready completes the handoff, and the new set is accepted on the following cycle.
- Reset mid-operation: assert rst during the second CONV cycle of (0,9,9,9) -> the next cycle shows out = 0, out_valid = 0, err = 0, in_ready = 1, and no out_valid pulse ever appears. A following (0,0,4,2) yields 0x002A.
- Back-to-back: stream 0..999 and -999..-1 with in_valid and out_ready held high -> every result matches the reference integer, acceptances are spaced 6 cycles apart, and changing the inputs after acceptance has no effect.

Source files
------------

// File: rtl/dec2bin_encoder_if.sv
// Handshake bundle for the decimal-to-binary encoder: digit set in, result out.
`timescale 1ns/1ps
interface dec2bin_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  digit3;
  logic [3:0]  digit2;
  logic [3:0]  digit1;
  logic [3:0]  digit0;
  logic [15:0] out;
  logic        out_valid;
  logic        out_ready;
  logic        err;

  // Producer/consumer side (drives digits and out_ready).
  modport master (
    output in_valid, digit3, digit2, digit1, digit0, out_ready,
    input  in_ready, out, out_valid, err
  );

  // Encoder side.
  modport slave (
    input  in_valid, digit3, digit2, digit1, digit0, out_ready,
    output in_ready, out, out_valid, err
  );
endinterface

// File: rtl/dec2bin_encoder.sv
// Sequential sign + 3-digit BCD to 16-bit two's-complement encoder.
// One multiply-by-10-and-add step per clock, then a sign step, then the
// result is held until the consumer takes it.
`timescale 1ns/1ps
module dec2bin_encoder (
  input  logic              clk,
  input  logic              rst,
  dec2bin_encoder_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_SIGN = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             r_state;
  logic [1:0]         r_step;
  logic [9:0]         r_acc;
  logic [3:0]         r_d2;
  logic [3:0]         r_d1;
  logic [3:0]         r_d0;
  logic               r_minus;
  logic               r_bad;
  logic signed [15:0] r_out;
  logic               r_out_valid;
  logic               r_err;

  logic [3:0]         w_digit;
  logic [9:0]         w_acc_next;

  // Sign code must be plus (0) or minus (10); each magnitude digit must be BCD.
  function automatic logic digits_bad(input logic [3:0] s, input logic [3:0] h,
                                      input logic [3:0] t, input logic [3:0] u);
    return !((s == 4'd0) || (s == 4'd10)) || (h > 4'd9) || (t > 4'd9) || (u > 4'd9);
  endfunction

  // Magnitude to signed 16-bit result; an illegal digit set collapses to zero.
  // Minus zero naturally yields zero since 0 - 0 = 0.
  function automatic logic signed [15:0] apply_sign(input logic [9:0] mag,
                                                    input logic       neg,
                                                    input logic       bad);
    logic signed [15:0] w_mag;
    w_mag = signed'({6'd0, mag});
    if (bad)      return 16'sd0;
    else if (neg) return 16'sd0 - w_mag;
    else          return w_mag;
  endfunction

  // Select the digit for the current CONV step: hundreds, tens, units.
  always_comb begin
    w_digit = r_d0;
    unique case (r_step)
      2'd0:    w_digit = r_d2;
      2'd1:    w_digit = r_d1;
      default: w_digit = r_d0;
    endcase
  end

  // acc*10 as (acc<<3)+(acc<<1); a legal acc never exceeds 999 so 10 bits hold it.
  // Illegal digits may wrap, but that result is discarded in SIGN anyway.
  assign w_acc_next = (r_acc << 3) + (r_acc << 1) + {6'd0, w_digit};

  // Control FSM with registered outputs; reset aborts any conversion in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_step      <= 2'd0;
      r_acc       <= 10'd0;
      r_d2        <= 4'd0;
      r_d1        <= 4'd0;
      r_d0        <= 4'd0;
      r_minus     <= 1'b0;
      r_bad       <= 1'b0;
      r_out       <= 16'sd0;
      r_out_valid <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_d2    <= bus.digit2;
            r_d1    <= bus.digit1;
            r_d0    <= bus.digit0;
            r_minus <= (bus.digit3 == 4'd10);
            r_bad   <= digits_bad(bus.digit3, bus.digit2, bus.digit1, bus.digit0);
            r_acc   <= 10'd0;
            r_step  <= 2'd0;
            r_state <= S_CONV;
          end
        end
        S_CONV: begin
          r_acc <= w_acc_next;
          if (r_step == 2'd2) begin
            r_state <= S_SIGN;
          end else begin
            r_step <= r_step + 2'd1;
          end
        end
        S_SIGN: begin
          r_out       <= apply_sign(r_acc, r_minus, r_bad);
          r_err       <= r_bad;
          r_out_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          // out and err persist past the handoff; only out_valid drops.
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // in_ready depends on state alone, never on out_ready.
  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out       = r_out;
  assign bus.out_valid = r_out_valid;
  assign bus.err       = r_err;

endmodule

// File: tb/tb_dec2bin_encoder.sv
// Scoreboard bench for dec2bin_encoder: driver pushes expected results,
// a negedge monitor pops and compares whenever a result is presented.
`timescale 1ns/1ps
module tb_dec2bin_encoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dec2bin_encoder_if bus();

  dec2bin_encoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Posedge counter; after edge k it reads k.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] val;
    logic        err;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // out_ready source: 0 = low, 1 = high, 2 = random per cycle.
  int   ready_mode = 1;
  logic rnd_ready  = 1'b1;
  logic gap_mode   = 1'b0;
  always @(posedge clk) rnd_ready <= 1'($urandom_range(0, 1));
  assign bus.out_ready = (ready_mode == 1) || ((ready_mode == 2) && rnd_ready);

  // Reference: value = 100*h + 10*t + u, negated for sign 10, zero when illegal.
  function automatic logic [16:0] model(input int s, input int h, input int t, input int u);
    bit bad;
    int v;
    bad = !((s == 0) || (s == 10)) || (h > 9) || (t > 9) || (u > 9);
    v   = 100 * h + 10 * t + u;
    if (bad)          v = 0;
    else if (s == 10) v = -v;
    return {bad, 16'(v)};
  endfunction

  // ---------------- monitor ----------------
  logic        prev_hold = 1'b0;
  logic        was_rst   = 1'b1;
  logic        pend_acc  = 1'b0;
  logic [15:0] held_out;
  logic        held_err;
  int          last_acc  = 0;
  int          acc_edge;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               nm, act, act, exp, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      prev_hold = 1'b0;
      was_rst   = 1'b1;
      pend_acc  = 1'b0;
      last_acc  = 0;
    end else begin
      if (was_rst) begin
        chk("reset_out",       int'(bus.out),       0);
        chk("reset_out_valid", int'(bus.out_valid), 0);
        chk("reset_err",       int'(bus.err),       0);
        chk("reset_in_ready",  int'(bus.in_ready),  1);
      end
      was_rst = 1'b0;

      if (pend_acc) begin
        chk("accept_after_handoff", int'(bus.in_valid && bus.in_ready), 1);
        pend_acc = 1'b0;
      end

      if (bus.in_valid && bus.in_ready) begin
        acc_edge = cyc + 1;
        if (gap_mode && last_acc > 0) chk("accept_spacing", acc_edge - last_acc, 6);
        last_acc = acc_edge;
      end

      if (bus.out_valid) begin
        chk("in_ready_low_while_valid", int'(bus.in_ready), 0);
        if (!prev_hold) begin
          if (sb.size() == 0) begin
            chk("unexpected_out_valid", 1, 0);
          end else begin
            chk("latency", cyc, sb[0].acc + 4);
            chk("out",     int'(bus.out), int'(sb[0].val));
            chk("err",     int'(bus.err), int'(sb[0].err));
          end
          held_out = bus.out;
          held_err = bus.err;
        end else begin
          chk("stall_out_stable", int'(bus.out), int'(held_out));
          chk("stall_err_stable", int'(bus.err), int'(held_err));
        end
        if (bus.out_ready) begin
          if (sb.size() > 0) void'(sb.pop_front());
          if (bus.in_valid) pend_acc = 1'b1;
        end
        prev_hold = !bus.out_ready;
      end else begin
        prev_hold = 1'b0;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic submit(input int s, input int h, input int t, input int u);
    exp_t        e;
    logic [16:0] m;
    int          n;
    bus.digit3   = 4'(s);
    bus.digit2   = 4'(h);
    bus.digit1   = 4'(t);
    bus.digit0   = 4'(u);
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready) begin
      tick();
      n++;
      if (n > 100) begin
        $display("FAIL submit_timeout: in_ready stayed 0 for %0d cycles, expected 1", n);
        $fatal(1, "bench stopped");
      end
    end
    m     = model(s, h, t, u);
    e.val = m[15:0];
    e.err = m[16];
    e.acc = cyc + 1;
    sb.push_back(e);
    tick();
    // Scramble the inputs after acceptance; the captured set must win.
    bus.in_valid = 1'b0;
    bus.digit3   = 4'($urandom);
    bus.digit2   = 4'($urandom);
    bus.digit1   = 4'($urandom);
    bus.digit0   = 4'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 || !bus.in_ready) begin
      tick();
      n++;
      if (n > 200) begin
        $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
        $fatal(1, "bench stopped");
      end
    end
    tick();
  endtask

  // Start (0,9,9,9), assert reset in the second CONV cycle, then idle.
  task automatic reset_mid();
    submit(0, 9, 9, 9);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (12) tick();
  endtask

  initial begin
    int sv, v, r;
    bus.in_valid = 1'b0;
    bus.digit3   = 4'd0;
    bus.digit2   = 4'd0;
    bus.digit1   = 4'd0;
    bus.digit0   = 4'd0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b0;
    tick();

    // Directed values and error cases.
    submit(0, 9, 9, 9);
    drain();
    submit(10, 9, 9, 9);
    submit(10, 1, 2, 3);
    submit(10, 0, 0, 0);
    submit(0, 1, 12, 3);
    submit(7, 0, 0, 1);
    submit(0, 0, 0, 5);
    drain();

    // Reset mid-conversion right after an error result.
    submit(7, 0, 0, 1);
    drain();
    reset_mid();
    submit(0, 0, 4, 2);
    drain();

    // Backpressure: hold 0x01C8 for 10 cycles while a new set is offered.
    ready_mode = 0;
    submit(0, 4, 5, 6);
    r = 0;
    while (!bus.out_valid) begin
      tick();
      r++;
      if (r > 50) begin
        $display("FAIL out_valid_timeout: out_valid stayed 0, expected 1");
        $fatal(1, "bench stopped");
      end
    end
    bus.digit3   = 4'd0;
    bus.digit2   = 4'd0;
    bus.digit1   = 4'd1;
    bus.digit0   = 4'd7;
    bus.in_valid = 1'b1;
    repeat (10) tick();
    ready_mode = 1;
    submit(0, 0, 1, 7);
    drain();

    // Reset mid-conversion after a nonzero result.
    reset_mid();
    submit(0, 0, 4, 2);
    drain();

    // Randomized digit sets with random consumer backpressure.
    ready_mode = 2;
    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 9);
      if (r < 4)      sv = 0;
      else if (r < 8) sv = 10;
      else            sv = $urandom_range(0, 15);
      submit(sv,
             ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 9),
             ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 9),
             ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 9));
      repeat ($urandom_range(0, 3)) tick();
    end
    ready_mode = 1;
    drain();

    // Back-to-back stream 0..999 then -999..-1.
    for (v = 0; v <= 999; v++) begin
      submit(0, v / 100, (v / 10) % 10, v % 10);
      gap_mode = 1'b1;
    end
    for (v = 999; v >= 1; v--) begin
      submit(10, v / 100, (v / 10) % 10, v % 10);
    end
    gap_mode = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
